count_event_logger: RTL and testbench
=====================================

COUNT_EVENT_LOGGER -- requirements
Module: count_event_logger

Interface
REQ-001 Parameter: DEPTH, 8, record FIFO depth; power of two, minimum 2.
REQ-002 Parameter: STAT_W, 8, width of the saturating statistic counters.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 count_in  input  9  registered count value from the up/down counter stage.
REQ-006 carry_in  input  1  counter carry flag, same cycle as count_in.
REQ-007 borrow_in  input  1  counter borrow flag, same cycle as count_in.
REQ-008 parity_in  input  1  counter parity flag, same cycle as count_in.
REQ-009 clr  input  1  synchronous clear of statistics and sticky flags.
REQ-010 rec_valid  output  1  FIFO head record available.
REQ-011 rec_ready  input  1  consumer accepts head record.
REQ-012 rec_data  output  11  {type[1:0], count[8:0]}; type 01 carry, 10 borrow, 11 both.
REQ-013 fifo_level  output  $clog2(DEPTH)+1  records currently stored.
REQ-014 carry_cnt, borrow_cnt, drop_cnt  output  STAT_W each  saturating event and drop counters.
REQ-015 overflow  output  1  sticky: at least one record dropped.
REQ-016 parity_err  output  1  sticky: parity_in disagreed with count_in.

Function
REQ-017 Event cycle: any rising edge with carry_in | borrow_in = 1; each such cycle is one event (level-sensitive, no edge detection).
REQ-018 On an event, the block SHALL push {borrow_in, carry_in, count_in} into the FIFO at that edge; rec_valid rises the following cycle (latency 1).
REQ-019 FIFO is show-ahead: rec_data SHALL equal the head record whenever rec_valid = 1; rec_data is don't-care when rec_valid = 0.
REQ-020 Pop occurs on an edge with rec_valid & rec_ready; rec_valid/rec_data SHALL hold stable while rec_valid & !rec_ready.
REQ-021 rec_valid SHALL equal (fifo_level != 0); rec_valid SHALL NOT depend combinationally on rec_ready.
REQ-022 Push while full without pop: record dropped, FIFO unchanged, overflow set, drop_cnt incremented.
REQ-023 Push while full with simultaneous pop: push accepted, fifo_level unchanged, no drop.
REQ-024 Push and pop while not full and not empty: fifo_level unchanged, order preserved.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; fifo_level SHALL range 0..DEPTH.
REQ-026 carry_cnt increments on each event with carry_in = 1; borrow_cnt on each with borrow_in = 1; type 11 increments both.
REQ-027 All statistic counters SHALL saturate at 2^STAT_W-1 and never wrap.
REQ-028 clr SHALL zero carry_cnt, borrow_cnt, drop_cnt, overflow, parity_err at that edge; FIFO contents unaffected.
REQ-029 clr coincident with an event: clr wins for statistics (counters end at 0); the record is still pushed or dropped per REQ-022..023.

Reset
REQ-030 reset SHALL, at the edge, empty the FIFO (pointers 0, fifo_level 0, rec_valid 0) and zero carry_cnt, borrow_cnt, drop_cnt, overflow, parity_err.
REQ-031 reset SHALL take priority over clr, push and pop; FIFO storage array need not be reset.
REQ-032 reset asserted mid-operation discards all stored records; the first event after reset deassertion is accepted normally.

Configuration
REQ-033 Macro COUNT_EVENT_LOGGER_PARITY_CHECK_EN: when defined, every cycle compares parity_in with ^count_in and sets parity_err on mismatch (clr/reset clear it; clr wins if coincident).
REQ-034 Without the macro, parity_err SHALL be constant 0 and parity_in unused; all other behaviour identical.

Verification
REQ-035 Reset, then carry_in=1 with count_in=9'h002 for one cycle, rec_ready=1 -> next cycle rec_valid=1, rec_data=11'b01_000000010, carry_cnt=1; following cycle fifo_level=0.
REQ-036 rec_ready=0, DEPTH+2 consecutive borrow events -> fifo_level=8, overflow=1, drop_cnt=2, borrow_cnt=10; drained order equals first 8 count_in values.
REQ-037 FIFO full, rec_ready=1 plus event same cycle -> fifo_level stays 8, drop_cnt unchanged, new record appears last.
REQ-038 carry_in=borrow_in=1, count_in=9'h1FF -> record type 11; carry_cnt and borrow_cnt both +1; STAT_W=2 run of 5 carries -> carry_cnt=3.
REQ-039 With macro: count_in=9'h001, parity_in=0 -> parity_err=1 next cycle; clr -> 0; without macro same stimulus -> parity_err stays 0.
REQ-040 Three records stored, reset asserted one cycle -> rec_valid=0, fifo_level=0, all counters 0 next cycle.

Source files
------------

// File: rtl/count_event_logger.sv
// Counter event logger: queues carry/borrow records in a show-ahead FIFO and keeps saturating statistics.
// Optional parity monitoring is compiled in with COUNT_EVENT_LOGGER_PARITY_CHECK_EN.
module count_event_logger #(
  parameter int DEPTH  = 8,
  parameter int STAT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [8:0]               count_in,
  input  logic                     carry_in,
  input  logic                     borrow_in,
  input  logic                     parity_in,
  input  logic                     clr,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [10:0]              rec_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [STAT_W-1:0]        carry_cnt,
  output logic [STAT_W-1:0]        borrow_cnt,
  output logic [STAT_W-1:0]        drop_cnt,
  output logic                     overflow,
  output logic                     parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [10:0]       mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [STAT_W-1:0] carryCnt_q, carryCnt_d;
  logic [STAT_W-1:0] borrowCnt_q, borrowCnt_d;
  logic [STAT_W-1:0] dropCnt_q, dropCnt_d;
  logic              overflow_q, overflow_d;

  logic evt, full, empty, push, pop, drop;

  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // A pop frees a slot in the same cycle, so a push into a full FIFO only drops without a pop.
  always_comb begin
    evt   = carry_in | borrow_in;
    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    pop   = !empty && rec_ready;
    push  = evt && (!full || pop);
    drop  = evt && full && !pop;

    wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    carryCnt_d  = clr ? '0 : satInc(carryCnt_q, carry_in);
    borrowCnt_d = clr ? '0 : satInc(borrowCnt_q, borrow_in);
    dropCnt_d   = clr ? '0 : satInc(dropCnt_q, drop);
    overflow_d  = clr ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      carryCnt_q  <= '0;
      borrowCnt_q <= '0;
      dropCnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      carryCnt_q  <= carryCnt_d;
      borrowCnt_q <= borrowCnt_d;
      dropCnt_q   <= dropCnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wrPtr_q] <= {borrow_in, carry_in, count_in};
    end
  end

`ifdef COUNT_EVENT_LOGGER_PARITY_CHECK_EN
  logic parityErr_q, parityErr_d;

  always_comb begin
    parityErr_d = clr ? 1'b0 : (parityErr_q | (parity_in != (^count_in)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parityErr_q <= 1'b0;
    end else begin
      parityErr_q <= parityErr_d;
    end
  end

  assign parity_err = parityErr_q;
`else
  logic unusedParity;
  assign unusedParity = parity_in;
  assign parity_err   = 1'b0;
`endif

  assign rec_valid  = !empty;
  assign rec_data   = mem_q[rdPtr_q];
  assign fifo_level = level_q;
  assign carry_cnt  = carryCnt_q;
  assign borrow_cnt = borrowCnt_q;
  assign drop_cnt   = dropCnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_count_event_logger.sv
// Self-checking bench for count_event_logger: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_count_event_logger;

  localparam int DEPTH  = 8;
  localparam int STAT_W = 8;
  localparam int SATMAX = (1 << STAT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [8:0]        count_in;
  logic              carry_in, borrow_in, parity_in, clr;
  logic              rec_valid, rec_ready;
  logic [10:0]       rec_data;
  logic [3:0]        fifo_level;
  logic [STAT_W-1:0] carry_cnt, borrow_cnt, drop_cnt;
  logic              overflow, parity_err;

  count_event_logger #(.DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
    .clock(clock), .reset(reset), .count_in(count_in), .carry_in(carry_in),
    .borrow_in(borrow_in), .parity_in(parity_in), .clr(clr),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .fifo_level(fifo_level), .carry_cnt(carry_cnt), .borrow_cnt(borrow_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  logic [10:0] modelQ[$];
  int mCarry, mBorrow, mDrop;
  bit mOverflow, mParity;
  int checks = 0;
  int passes = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int satAdd(input int v);
    return (v < SATMAX) ? v + 1 : SATMAX;
  endfunction

  // Reference behaviour: pop the head first, then an event enters if a slot is free, else it is dropped.
  task automatic updateModel(input bit c, input bit b, input bit p, input logic [8:0] cnt,
                             input bit rdy, input bit clrV, input bit rst);
    bit dropped;
    dropped = 0;
    if (rst) begin
      modelQ.delete();
      mCarry = 0; mBorrow = 0; mDrop = 0; mOverflow = 0; mParity = 0;
      return;
    end
    if (rdy && modelQ.size() != 0) void'(modelQ.pop_front());
    if (c || b) begin
      if (modelQ.size() < DEPTH) modelQ.push_back({b, c, cnt});
      else dropped = 1;
    end
    if (clrV) begin
      mCarry = 0; mBorrow = 0; mDrop = 0; mOverflow = 0; mParity = 0;
    end else begin
      if (c) mCarry = satAdd(mCarry);
      if (b) mBorrow = satAdd(mBorrow);
      if (dropped) begin
        mDrop = satAdd(mDrop);
        mOverflow = 1;
      end
`ifdef COUNT_EVENT_LOGGER_PARITY_CHECK_EN
      if (p != (^cnt)) mParity = 1;
`endif
    end
  endtask

  task automatic checkOutput();
    checkVal("rec_valid", rec_valid, modelQ.size() != 0);
    checkVal("fifo_level", fifo_level, modelQ.size());
    if (modelQ.size() != 0) checkVal("rec_data", rec_data, modelQ[0]);
    checkVal("carry_cnt", carry_cnt, mCarry);
    checkVal("borrow_cnt", borrow_cnt, mBorrow);
    checkVal("drop_cnt", drop_cnt, mDrop);
    checkVal("overflow", overflow, mOverflow);
    checkVal("parity_err", parity_err, mParity);
  endtask

  task automatic applyStimulus(input bit c, input bit b, input bit p, input logic [8:0] cnt,
                               input bit rdy, input bit clrV, input bit rst);
    carry_in = c; borrow_in = b; parity_in = p; count_in = cnt;
    rec_ready = rdy; clr = clrV; reset = rst;
    @(posedge clock);
    updateModel(c, b, p, cnt, rdy, clrV, rst);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [8:0] cnt;
    bit c, b, p, rdy, clrV, rst;

    applyStimulus(0, 0, 0, 9'h000, 0, 0, 1);
    applyStimulus(0, 0, 0, 9'h000, 0, 0, 1);
    checkVal("reset_level_direct", fifo_level, 0);

    // Single carry event with consumer ready, then idle.
    applyStimulus(1, 0, 1, 9'h002, 1, 0, 0);
    checkVal("first_rec_direct", rec_data, 11'b01_000000010);
    applyStimulus(0, 0, 0, 9'h002, 1, 0, 0);

    // DEPTH+2 borrow events with consumer stalled, then drain.
    for (int i = 0; i < DEPTH + 2; i++) begin
      cnt = 9'(9'h010 + i);
      applyStimulus(0, 1, ^cnt, cnt, 0, 0, 0);
    end
    checkVal("drop_after_fill", drop_cnt, 2);
    // Full FIFO with simultaneous pop and push: no drop, new record enters at the tail.
    applyStimulus(1, 0, ^9'h0AA, 9'h0AA, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 9'h000, 1, 0, 0);

    // Both flags at once, then a parity mismatch followed by clr.
    applyStimulus(1, 1, 1, 9'h1FF, 1, 0, 0);
    applyStimulus(0, 0, 0, 9'h001, 1, 0, 0);
    applyStimulus(0, 0, 0, 9'h000, 1, 1, 0);

    // clr coincident with an event: statistics clear, record still stored.
    applyStimulus(1, 0, 0, 9'h000, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      c    = ($urandom_range(0, 2) == 0);
      b    = ($urandom_range(0, 2) == 0);
      cnt  = 9'($urandom);
      p    = ($urandom_range(0, 15) == 0) ? !(^cnt) : (^cnt);
      rdy  = ($urandom_range(0, 1) == 0);
      clrV = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 149) == 0);
      applyStimulus(c, b, p, cnt, rdy, clrV, rst);
    end

    // Saturate every statistic counter.
    for (int i = 0; i < SATMAX + 15; i++) begin
      cnt = 9'($urandom);
      applyStimulus(1, 1, ^cnt, cnt, 0, 0, 0);
    end
    checkVal("carry_saturated", carry_cnt, SATMAX);
    checkVal("drop_saturated", drop_cnt, SATMAX);
    applyStimulus(0, 0, 0, 9'h000, 0, 1, 0);

    // Reset with records stored discards them; next event is accepted.
    applyStimulus(0, 0, 0, 9'h000, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 9'(i + 1), 0, 0, 0);
    applyStimulus(0, 0, 0, 9'h000, 0, 0, 1);
    checkVal("reset_valid_direct", rec_valid, 0);
    applyStimulus(0, 1, 0, 9'h033, 0, 0, 0);
    applyStimulus(0, 0, 0, 9'h000, 1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
